skew_feeder: RTL and testbench

SKEW_FEEDER -- requirements
Module: skew_feeder

---
 rtl/skew_feeder_pkg.sv | 36 +++
 rtl/feeder_row_buf.sv | 40 ++++
 rtl/skew_feeder.sv | 181 ++++++++++++++++++
 tb/tb_skew_feeder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/skew_feeder_pkg.sv
// Shared definitions for the skew feeder and its accumulator: FSM state
// encoding, parameter defaults and the derived-width helpers.
package skew_feeder_pkg;

    localparam int SF_DEPTH_DEFAULT      = 8;
    localparam int SF_ARRAY_M_DEFAULT    = 8;
    localparam int SF_DATA_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        EMIT  = 2'd2,
        DRAIN = 2'd3
    } feeder_state_e;

    // Width of one full row (all lanes side by side).
    function automatic int data_set_width(input int array_m, input int data_width);
        return array_m * data_width;
    endfunction

    // Counter width covering both the row count and the emit index range.
    function automatic int cnt_width(input int depth, input int array_m);
        return $clog2(depth + array_m);
    endfunction

    // Row-buffer index width; at least one bit so DEPTH=1 still elaborates.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Width of the num_cols input, wide enough to hold ARRAY_M itself.
    function automatic int num_cols_width(input int array_m);
        return $clog2(array_m) + 1;
    endfunction

endpackage

// File: rtl/feeder_row_buf.sv
// Row buffer for one tile: a single row-wide write port and an independent
// registered read index per lane, so every lane can look at a different row.
module feeder_row_buf
    import skew_feeder_pkg::*;
#(
    parameter int DEPTH      = SF_DEPTH_DEFAULT,
    parameter int ARRAY_M    = SF_ARRAY_M_DEFAULT,
    parameter int DATA_WIDTH = SF_DATA_WIDTH_DEFAULT,
    localparam int DSW       = data_set_width(ARRAY_M, DATA_WIDTH),
    localparam int IDX_W     = idx_width(DEPTH)
) (
    input  logic                     clk_i,
    input  logic                     wr_en_i,
    input  logic [IDX_W-1:0]         wr_idx_i,
    input  logic [DSW-1:0]           wr_data_i,
    input  logic [ARRAY_M*IDX_W-1:0] rd_idx_i,
    output logic [DSW-1:0]           rd_data_o
);

    logic [DSW-1:0] mem_q [DEPTH];
    logic [DSW-1:0] rd_data_q;

    // Row write; contents are never cleared, stale rows are masked downstream.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    // Per-lane registered read: lane c takes its slice from row rd_idx[c].
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < ARRAY_M; c++) begin
            rd_data_q[c*DATA_WIDTH +: DATA_WIDTH] <=
                mem_q[rd_idx_i[c*IDX_W +: IDX_W]][c*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/skew_feeder.sv
// Skew feeder: buffers DEPTH rows, then streams them out diagonally so lane c
// lags lane 0 by c cycles, and finishes each tile with a one-cycle drain pulse.
//
// Input handshake: a row is transferred on every rising edge where in_valid
// and in_ready are both 1; in_ready is 1 only in LOAD and never depends on
// in_valid. Output stream: out_valid has no back-pressure; data_set_out is
// meaningful only while out_valid is 1 and is forced to 0 otherwise.
//
// Emit pipeline: EMIT index k drives the row-buffer read indices, the buffer
// registers the lane slices (stage 1), and the masked result is registered
// onto data_set_out (stage 2), so out_valid rises two edges after the last
// row is accepted.
module skew_feeder
    import skew_feeder_pkg::*;
#(
    parameter int DEPTH      = SF_DEPTH_DEFAULT,
    parameter int ARRAY_M    = SF_ARRAY_M_DEFAULT,
    parameter int DATA_WIDTH = SF_DATA_WIDTH_DEFAULT,
    localparam int DATA_SET_WIDTH = data_set_width(ARRAY_M, DATA_WIDTH),
    localparam int CNT_WIDTH      = cnt_width(DEPTH, ARRAY_M),
    localparam int NC_WIDTH       = num_cols_width(ARRAY_M)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [NC_WIDTH-1:0]       num_cols,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_SET_WIDTH-1:0] in_data,
    output logic                      out_valid,
    output logic [DATA_SET_WIDTH-1:0] data_set_out,
    output logic                      drain_out,
    output logic                      busy,
    output feeder_state_e             dbg_state
);

    localparam int IDX_WIDTH = idx_width(DEPTH);
    localparam int LAST_EMIT = DEPTH + ARRAY_M - 2;

    feeder_state_e              state_q, state_d;
    logic [CNT_WIDTH-1:0]       row_cnt_q, row_cnt_d;
    logic [CNT_WIDTH-1:0]       emit_cnt_q, emit_cnt_d;
    logic [NC_WIDTH-1:0]        num_cols_q, num_cols_d;
    logic                       pipe_valid_q;
    logic [ARRAY_M-1:0]         lane_en_q, lane_en_d;
    logic                       out_valid_q;
    logic [DATA_SET_WIDTH-1:0]  data_q, data_d;
    logic                       drain_q, drain_d;
    logic                       busy_q, busy_d;

    logic                       load_ready;
    logic                       accept;
    logic                       last_row;
    logic                       emit_active;
    logic                       last_emit;
    logic                       drain_fire;
    logic [ARRAY_M*IDX_WIDTH-1:0] rd_idx;
    logic [DATA_SET_WIDTH-1:0]  rd_data;

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; start only matters while already sitting in IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start)      state_d = LOAD;
            LOAD:  if (last_row)   state_d = EMIT;
            EMIT:  if (last_emit)  state_d = DRAIN;
            DRAIN: if (drain_q)    state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    // FSM decoded outputs and per-cycle events.
    always_comb begin
        load_ready  = (state_q == LOAD);
        accept      = load_ready && in_valid;
        last_row    = accept && (row_cnt_q == CNT_WIDTH'(DEPTH - 1));
        emit_active = (state_q == EMIT);
        last_emit   = emit_active && (emit_cnt_q == CNT_WIDTH'(LAST_EMIT));
        // Fire once the final emitted row is on the output and nothing follows.
        drain_fire  = (state_q == DRAIN) && out_valid_q && !pipe_valid_q && !drain_q;
    end

    // Counter and configuration next values; both counters wrap per tile.
    always_comb begin
        row_cnt_d  = row_cnt_q;
        emit_cnt_d = emit_cnt_q;
        num_cols_d = num_cols_q;
        if (accept) begin
            row_cnt_d = last_row ? '0 : row_cnt_q + CNT_WIDTH'(1);
        end
        if (emit_active) begin
            emit_cnt_d = last_emit ? '0 : emit_cnt_q + CNT_WIDTH'(1);
        end
        if ((state_q == IDLE) && start) begin
            num_cols_d = (num_cols > NC_WIDTH'(ARRAY_M)) ? NC_WIDTH'(ARRAY_M) : num_cols;
        end
        busy_d  = (state_d != IDLE);
        drain_d = drain_fire;
    end

    // Skew mux control: lane c reads row k-c while inside its diagonal window.
    always_comb begin
        logic [CNT_WIDTH-1:0] diff;
        diff      = '0;
        rd_idx    = '0;
        lane_en_d = '0;
        for (int c = 0; c < ARRAY_M; c++) begin
            diff = emit_cnt_q - CNT_WIDTH'(c);
            rd_idx[c*IDX_WIDTH +: IDX_WIDTH] = diff[IDX_WIDTH-1:0];
            lane_en_d[c] = emit_active
                        && (emit_cnt_q >= CNT_WIDTH'(c))
                        && (emit_cnt_q <  CNT_WIDTH'(DEPTH + c))
                        && (NC_WIDTH'(c) < num_cols_q);
        end
    end

    // Output stage data: disabled lanes and idle cycles present zero.
    always_comb begin
        data_d = '0;
        for (int c = 0; c < ARRAY_M; c++) begin
            if (lane_en_q[c]) begin
                data_d[c*DATA_WIDTH +: DATA_WIDTH] = rd_data[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Counters, emit pipeline and registered outputs; reset abandons any tile.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_cnt_q    <= '0;
            emit_cnt_q   <= '0;
            num_cols_q   <= '0;
            pipe_valid_q <= 1'b0;
            lane_en_q    <= '0;
            out_valid_q  <= 1'b0;
            data_q       <= '0;
            drain_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            row_cnt_q    <= row_cnt_d;
            emit_cnt_q   <= emit_cnt_d;
            num_cols_q   <= num_cols_d;
            pipe_valid_q <= emit_active;
            lane_en_q    <= lane_en_d;
            out_valid_q  <= pipe_valid_q;
            data_q       <= data_d;
            drain_q      <= drain_d;
            busy_q       <= busy_d;
        end
    end

    feeder_row_buf #(
        .DEPTH      (DEPTH),
        .ARRAY_M    (ARRAY_M),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_row_buf (
        .clk_i     (clk),
        .wr_en_i   (accept),
        .wr_idx_i  (row_cnt_q[IDX_WIDTH-1:0]),
        .wr_data_i (in_data),
        .rd_idx_i  (rd_idx),
        .rd_data_o (rd_data)
    );

    assign in_ready     = load_ready;
    assign out_valid    = out_valid_q;
    assign data_set_out = data_q;
    assign drain_out    = drain_q;
    assign busy         = busy_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_skew_feeder.sv
// Directed bench for skew_feeder (DEPTH=8, ARRAY_M=8, DATA_WIDTH=32).
module tb_skew_feeder;
  import skew_feeder_pkg::*;

  localparam int DEPTH    = 8;
  localparam int ARRAY_M  = 8;
  localparam int DW       = 32;
  localparam int DSW      = ARRAY_M * DW;
  localparam int NCW      = 4;
  localparam int EMIT_LEN = DEPTH + ARRAY_M - 1;

  // ---------------- clock / reset / DUT ----------------
  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [NCW-1:0] num_cols;
  logic           in_valid;
  logic           in_ready;
  logic [DSW-1:0] in_data;
  logic           out_valid;
  logic [DSW-1:0] data_set_out;
  logic           drain_out;
  logic           busy;
  feeder_state_e  dbg_state;

  always #5 clk = ~clk;

  skew_feeder #(
    .DEPTH      (DEPTH),
    .ARRAY_M    (ARRAY_M),
    .DATA_WIDTH (DW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .num_cols     (num_cols),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .data_set_out (data_set_out),
    .drain_out    (drain_out),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [DSW-1:0] act, input logic [DSW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  task automatic check_s(input string name, input feeder_state_e act, input feeder_state_e exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // ---------------- stimulus model ----------------
  // Lane c of row r carries a value naming both, so swaps are visible.
  function automatic logic [DW-1:0] row_val(input int r, input int c);
    return DW'(32'h5A00_0000 + r * 256 + c);
  endfunction

  function automatic logic [DSW-1:0] make_row(input int r);
    logic [DSW-1:0] v;
    v = '0;
    for (int c = 0; c < ARRAY_M; c++) v[c*DW +: DW] = row_val(r, c);
    return v;
  endfunction

  function automatic logic [DSW-1:0] exp_vec(input int k, input logic [ARRAY_M-1:0] mask);
    logic [DSW-1:0] v;
    v = '0;
    for (int c = 0; c < ARRAY_M; c++)
      if (mask[c] && k >= c && k < c + DEPTH) v[c*DW +: DW] = row_val(k - c, c);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int               nc;       // num_cols driven with start
    int               gap;      // 1: in_valid pattern 1,0,0,1,0,0,...
    int               poke;     // 1: start pulses in LOAD/EMIT/DRAIN, in_valid high in EMIT
    int               abort_k;  // emit index at which reset is pulled, -1 for none
    logic [ARRAY_M-1:0] mask;   // hand-computed active lanes after clamping
  } tile_vec_t;

  tile_vec_t vecs[9];

  task automatic do_abort(input int vi);
    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    #1;
    check_b($sformatf("v%0d_abort_out_valid", vi), out_valid, 1'b0);
    check($sformatf("v%0d_abort_data", vi), data_set_out, '0);
    check_b($sformatf("v%0d_abort_drain", vi), drain_out, 1'b0);
    check_b($sformatf("v%0d_abort_busy", vi), busy, 1'b0);
    check_b($sformatf("v%0d_abort_in_ready", vi), in_ready, 1'b0);
    step();
    step();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_b($sformatf("v%0d_post_abort_drain%0d", vi, i), drain_out, 1'b0);
      check_b($sformatf("v%0d_post_abort_valid%0d", vi, i), out_valid, 1'b0);
    end
    check_s($sformatf("v%0d_post_abort_state", vi), dbg_state, IDLE);
  endtask

  task automatic run_tile(input int vi);
    tile_vec_t v;
    int acc;
    int cyc;
    v   = vecs[vi];
    acc = 0;
    cyc = 0;

    start    = 1'b1;
    num_cols = NCW'(v.nc);
    in_valid = 1'b0;
    step();
    start = 1'b0;
    check_b($sformatf("v%0d_busy_start", vi), busy, 1'b1);
    check_s($sformatf("v%0d_state_load", vi), dbg_state, LOAD);

    while (acc < DEPTH && cyc < 64) begin
      in_valid = v.gap ? (cyc % 3 == 0) : 1'b1;
      in_data  = in_valid ? make_row(acc) : {DSW{1'b1}};
      start    = (v.poke != 0) && (cyc == 2);
      check_b($sformatf("v%0d_in_ready_load%0d", vi, cyc), in_ready, 1'b1);
      step();
      if (in_valid) acc++;
      cyc++;
    end
    if (acc < DEPTH) check_b($sformatf("v%0d_load_budget", vi), 1'b0, 1'b1);
    if (v.gap) check_b($sformatf("v%0d_gap_cycles", vi), cyc == 22, 1'b1);

    start    = 1'b0;
    in_valid = (v.poke != 0);
    in_data  = {ARRAY_M{32'hDEAD_BEEF}};
    check_b($sformatf("v%0d_valid_e0", vi), out_valid, 1'b0);
    check_b($sformatf("v%0d_in_ready_emit", vi), in_ready, 1'b0);
    check_s($sformatf("v%0d_state_emit", vi), dbg_state, EMIT);
    step();
    check_b($sformatf("v%0d_valid_e1", vi), out_valid, 1'b0);
    check($sformatf("v%0d_data_e1", vi), data_set_out, '0);
    step();

    for (int k = 0; k < EMIT_LEN; k++) begin
      check_b($sformatf("v%0d_valid_k%0d", vi, k), out_valid, 1'b1);
      check($sformatf("v%0d_data_k%0d", vi, k), data_set_out, exp_vec(k, v.mask));
      check_b($sformatf("v%0d_in_ready_k%0d", vi, k), in_ready, 1'b0);
      check_b($sformatf("v%0d_drain_k%0d", vi, k), drain_out, 1'b0);
      if (k == v.abort_k) begin
        do_abort(vi);
        return;
      end
      start = (v.poke != 0) && (k == 3);
      step();
    end

    // Start held in the drain cycle must not open a new tile.
    start = (v.poke != 0);
    check_b($sformatf("v%0d_valid_end", vi), out_valid, 1'b0);
    check($sformatf("v%0d_data_end", vi), data_set_out, '0);
    check_b($sformatf("v%0d_drain_pulse", vi), drain_out, 1'b1);
    check_b($sformatf("v%0d_busy_drain", vi), busy, 1'b1);
    step();
    start    = 1'b0;
    in_valid = 1'b0;
    check_b($sformatf("v%0d_drain_off", vi), drain_out, 1'b0);
    check_b($sformatf("v%0d_busy_off", vi), busy, 1'b0);
    check_s($sformatf("v%0d_state_idle", vi), dbg_state, IDLE);
    step();
    check_b($sformatf("v%0d_busy_idle", vi), busy, 1'b0);
    check_b($sformatf("v%0d_drain_idle", vi), drain_out, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vecs[0] = '{8,  0, 0, -1, 8'hFF};
    vecs[1] = '{3,  0, 0, -1, 8'h07};
    vecs[2] = '{8,  1, 0, -1, 8'hFF};
    vecs[3] = '{8,  0, 1, -1, 8'hFF};
    vecs[4] = '{0,  0, 0, -1, 8'h00};
    vecs[5] = '{15, 0, 0, -1, 8'hFF};
    vecs[6] = '{8,  0, 0,  5, 8'hFF};
    vecs[7] = '{8,  0, 0, -1, 8'hFF};
    vecs[8] = '{1,  1, 1, -1, 8'h01};

    reset    = 1'b0;
    start    = 1'b0;
    num_cols = '0;
    in_valid = 1'b0;
    in_data  = '0;
    step();
    step();
    check_b("rst_out_valid", out_valid, 1'b0);
    check("rst_data", data_set_out, '0);
    check_b("rst_drain", drain_out, 1'b0);
    check_b("rst_busy", busy, 1'b0);
    check_b("rst_in_ready", in_ready, 1'b0);
    reset = 1'b1;
    step();
    check_b("rel_out_valid", out_valid, 1'b0);
    check_b("rel_in_ready", in_ready, 1'b0);
    check_b("rel_busy", busy, 1'b0);
    check_s("rel_state", dbg_state, IDLE);

    for (int i = 0; i < 9; i++) begin
      run_tile(i);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
